// File: rtl/ramp_sweep_ctrl_if.sv
// Control/config bundle between the PS-side register block, the sweep controller and the
// ramp generator's frequency/amplitude inputs.
interface ramp_sweep_ctrl_if #(
  parameter int unsigned FREQ_W  = 32,
  parameter int unsigned DWELL_W = 32,
  parameter int unsigned SWEEP_W = 16
);
  logic               start;
  logic               abort;
  logic [FREQ_W-1:0]  cfg_start_freq;
  logic [FREQ_W-1:0]  cfg_stop_freq;
  logic [FREQ_W-1:0]  cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [31:0]        cfg_amplitude;
  logic               cfg_mode;
  logic [SWEEP_W-1:0] cfg_num_sweeps;
  logic               beat;
  logic [FREQ_W-1:0]  frequency;
  logic [31:0]        amplitude;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [SWEEP_W-1:0] sweep_count;

  modport master (
    output start, abort, cfg_start_freq, cfg_stop_freq, cfg_step, cfg_dwell, cfg_amplitude,
           cfg_mode, cfg_num_sweeps, beat,
    input  frequency, amplitude, busy, done, cfg_err, sweep_count
  );

  modport slave (
    input  start, abort, cfg_start_freq, cfg_stop_freq, cfg_step, cfg_dwell, cfg_amplitude,
           cfg_mode, cfg_num_sweeps, beat,
    output frequency, amplitude, busy, done, cfg_err, sweep_count
  );
endinterface

// File: rtl/ramp_sweep_ctrl.sv
// Stepped frequency sweep sequencer: holds each frequency for a programmed number of accepted
// beats, then steps in sawtooth or triangle fashion for N sweeps or forever.
module ramp_sweep_ctrl #(
  parameter int unsigned FREQ_W  = 32,
  parameter int unsigned DWELL_W = 32,
  parameter int unsigned SWEEP_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  ramp_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StDwell, StAdvance} state_e;

  state_e state_q, state_d;

  // Shadow copies of the configuration, captured on an accepted start
  logic [FREQ_W-1:0]  start_q, start_d;
  logic [FREQ_W-1:0]  stop_q, stop_d;
  logic [FREQ_W-1:0]  step_q, step_d;
  logic [DWELL_W-1:0] dwell_cfg_q, dwell_cfg_d;
  logic [31:0]        amp_cfg_q, amp_cfg_d;
  logic               mode_q, mode_d;
  logic [SWEEP_W-1:0] num_q, num_d;

  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [31:0]        amp_q, amp_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_down_q, dir_down_d;
  logic [SWEEP_W-1:0] count_q, count_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cfg_ok;
  logic [DWELL_W-1:0] dwell_load;
  logic [FREQ_W:0]    up_sum, dn_diff;
  logic               up_ok, dn_ok;
  logic               sweep_done, final_sweep;
  logic [FREQ_W-1:0]  nxt_freq;
  logic               nxt_dir_down;
  logic [SWEEP_W-1:0] count_plus, count_sat;

  assign cfg_ok     = (bus.cfg_step != '0) && (bus.cfg_start_freq <= bus.cfg_stop_freq);
  assign dwell_load = (dwell_cfg_q == '0) ? DWELL_W'(1) : dwell_cfg_q;

  // Extra top bit catches carry on the way up and borrow on the way down
  assign up_sum  = {1'b0, freq_q} + {1'b0, step_q};
  assign dn_diff = {1'b0, freq_q} - {1'b0, step_q};
  assign up_ok   = !up_sum[FREQ_W] && (up_sum[FREQ_W-1:0] <= stop_q);
  assign dn_ok   = !dn_diff[FREQ_W] && (dn_diff[FREQ_W-1:0] >= start_q);

  always_comb begin
    sweep_done   = 1'b0;
    nxt_freq     = freq_q;
    nxt_dir_down = dir_down_q;
    if (!dir_down_q) begin
      if (up_ok) begin
        nxt_freq = up_sum[FREQ_W-1:0];
      end else if (!mode_q) begin
        sweep_done = 1'b1;
        nxt_freq   = start_q;
      end else begin
        nxt_dir_down = 1'b1;
        nxt_freq     = dn_ok ? dn_diff[FREQ_W-1:0] : start_q;
      end
    end else begin
      if (dn_ok) begin
        nxt_freq = dn_diff[FREQ_W-1:0];
      end else begin
        sweep_done   = 1'b1;
        nxt_dir_down = 1'b0;
        nxt_freq     = up_ok ? up_sum[FREQ_W-1:0] : stop_q;
      end
    end
  end

  assign count_plus  = count_q + SWEEP_W'(1);
  assign count_sat   = (count_q == '1) ? count_q : count_plus;
  assign final_sweep = sweep_done && (num_q != '0) && (count_plus == num_q);

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (bus.start && cfg_ok) state_d = StLoad;
        StLoad:    state_d = StDwell;
        StDwell:   if (bus.beat && (dwell_q == DWELL_W'(1))) state_d = StAdvance;
        StAdvance: state_d = final_sweep ? StIdle : StDwell;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Datapath / output next values
  always_comb begin
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_cfg_d = dwell_cfg_q;
    amp_cfg_d   = amp_cfg_q;
    mode_d      = mode_q;
    num_d       = num_q;
    freq_d      = freq_q;
    amp_d       = amp_q;
    dwell_d     = dwell_q;
    dir_down_d  = dir_down_q;
    count_d     = count_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    if (bus.abort) begin
      freq_d = '0;
      amp_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (cfg_ok) begin
              start_d     = bus.cfg_start_freq;
              stop_d      = bus.cfg_stop_freq;
              step_d      = bus.cfg_step;
              dwell_cfg_d = bus.cfg_dwell;
              amp_cfg_d   = bus.cfg_amplitude;
              mode_d      = bus.cfg_mode;
              num_d       = bus.cfg_num_sweeps;
              count_d     = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StLoad: begin
          freq_d     = start_q;
          amp_d      = amp_cfg_q;
          dwell_d    = dwell_load;
          dir_down_d = 1'b0;
        end
        StDwell: begin
          if (bus.beat) dwell_d = dwell_q - DWELL_W'(1);
        end
        StAdvance: begin
          dwell_d = dwell_load;
          if (sweep_done) count_d = count_sat;
          if (final_sweep) begin
            done_d = 1'b1;
            freq_d = '0;
            amp_d  = '0;
          end else begin
            freq_d     = nxt_freq;
            dir_down_d = nxt_dir_down;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_cfg_q <= '0;
      amp_cfg_q   <= '0;
      mode_q      <= 1'b0;
      num_q       <= '0;
      freq_q      <= '0;
      amp_q       <= '0;
      dwell_q     <= '0;
      dir_down_q  <= 1'b0;
      count_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_cfg_q <= dwell_cfg_d;
      amp_cfg_q   <= amp_cfg_d;
      mode_q      <= mode_d;
      num_q       <= num_d;
      freq_q      <= freq_d;
      amp_q       <= amp_d;
      dwell_q     <= dwell_d;
      dir_down_q  <= dir_down_d;
      count_q     <= count_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.frequency   = freq_q;
  assign bus.amplitude   = amp_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.cfg_err     = err_q;
  assign bus.sweep_count = count_q;

endmodule

// File: tb/tb_ramp_sweep_ctrl.sv
// Directed bench for ramp_sweep_ctrl: sweep shapes, dwell gating, config rejection,
// abort and reset.
module tb_ramp_sweep_ctrl;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  ramp_sweep_ctrl_if #(.FREQ_W(32), .DWELL_W(32), .SWEEP_W(16)) bus ();

  ramp_sweep_ctrl #(.FREQ_W(32), .DWELL_W(32), .SWEEP_W(16)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] seen_f[16];
  logic [31:0] seen_a[16];
  logic [15:0] seen_c[16];
  int          seen_hold[16];
  int          seen_n;
  int          done_cnt;

  localparam logic [31:0] SAW_F [4] = '{32'd100, 32'd110, 32'd120, 32'd130};
  localparam logic [31:0] TRI_F [9] = '{32'd100, 32'd110, 32'd120, 32'd110, 32'd100,
                                        32'd110, 32'd120, 32'd110, 32'd100};
  localparam logic [15:0] TRI_C [9] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                                        16'd1, 16'd1, 16'd1, 16'd1};

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                         input logic [31:0] dw, input logic mode, input logic [15:0] n);
    bus.cfg_start_freq = s;
    bus.cfg_stop_freq  = p;
    bus.cfg_step       = st;
    bus.cfg_dwell      = dw;
    bus.cfg_mode       = mode;
    bus.cfg_num_sweeps = n;
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_abort;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  // Record each distinct frequency value and how many cycles it was visible, until done
  task automatic collect(input int budget);
    logic [31:0] last;
    seen_n   = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      seen_f[i] = '0; seen_a[i] = '0; seen_c[i] = '0; seen_hold[i] = 0;
    end
    last = bus.frequency;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done) begin
        done_cnt++;
        break;
      end
      if (bus.frequency != last && seen_n < 16) begin
        seen_f[seen_n]    = bus.frequency;
        seen_a[seen_n]    = bus.amplitude;
        seen_c[seen_n]    = bus.sweep_count;
        seen_hold[seen_n] = 1;
        seen_n++;
      end else if (seen_n > 0) begin
        seen_hold[seen_n-1]++;
      end
      last = bus.frequency;
    end
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
    checks++;
    if (bus.frequency !== 32'd0 || bus.amplitude !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs freq=%0h amp=%0h expected 0 0", bus.frequency, bus.amplitude);
    end
    checks++;
    if ({bus.busy, bus.done, bus.cfg_err} !== 3'b000 || bus.sweep_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_flags busy/done/err=%b cnt=%0d expected 000 0",
               {bus.busy, bus.done, bus.cfg_err}, bus.sweep_count);
    end
  endtask

  task automatic test_sawtooth;
    set_cfg(32'd100, 32'd130, 32'd10, 32'd2, 1'b0, 16'd1);
    bus.cfg_amplitude = 32'h0000_5A5A;
    bus.beat = 1'b1;
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.frequency !== 32'd0) begin
      errors++;
      $display("FAIL saw_latency busy=%b freq=%0d expected 1 0", bus.busy, bus.frequency);
    end
    // Changes after the latch must be ignored
    bus.cfg_stop_freq = 32'd1000;
    bus.cfg_amplitude = 32'h1111_1111;
    collect(60);
    checks++;
    if (seen_n !== 4) begin
      errors++;
      $display("FAIL saw_count got %0d values expected 4", seen_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen_f[i] !== SAW_F[i] || seen_hold[i] !== 3) begin
        errors++;
        $display("FAIL saw_step%0d freq=%0d hold=%0d expected %0d 3",
                 i, seen_f[i], seen_hold[i], SAW_F[i]);
      end
    end
    checks++;
    if (seen_a[0] !== 32'h0000_5A5A) begin
      errors++;
      $display("FAIL saw_amplitude got %0h expected 5a5a", seen_a[0]);
    end
    checks++;
    if (done_cnt !== 1 || bus.frequency !== 32'd0 || bus.amplitude !== 32'd0 ||
        bus.busy !== 1'b0 || bus.sweep_count !== 16'd1) begin
      errors++;
      $display("FAIL saw_done done=%0d freq=%0d amp=%0h busy=%b cnt=%0d expected 1 0 0 0 1",
               done_cnt, bus.frequency, bus.amplitude, bus.busy, bus.sweep_count);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL saw_done_pulse done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_triangle;
    set_cfg(32'd100, 32'd125, 32'd10, 32'd1, 1'b1, 16'd2);
    bus.beat = 1'b1;
    pulse_start();
    collect(60);
    checks++;
    if (seen_n !== 9) begin
      errors++;
      $display("FAIL tri_count got %0d values expected 9", seen_n);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (seen_f[i] !== TRI_F[i] || seen_c[i] !== TRI_C[i] || seen_hold[i] !== 2) begin
        errors++;
        $display("FAIL tri_step%0d freq=%0d cnt=%0d hold=%0d expected %0d %0d 2",
                 i, seen_f[i], seen_c[i], seen_hold[i], TRI_F[i], TRI_C[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || bus.sweep_count !== 16'd2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL tri_done done=%0d cnt=%0d busy=%b expected 1 2 0",
               done_cnt, bus.sweep_count, bus.busy);
    end
  endtask

  task automatic test_carry_wrap;
    set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 32'd1, 1'b0, 16'd0);
    bus.beat = 1'b1;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (bus.frequency !== 32'hFFFF_FFF0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL carry_cycle%0d freq=%0h busy=%b done=%b expected fffffff0 1 0",
                 i, bus.frequency, bus.busy, bus.done);
      end
      // A start while busy is ignored, even with a bad config
      if (i == 4) begin
        bus.cfg_step = 32'd0;
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (i == 5) begin
        checks++;
        if (bus.cfg_err !== 1'b0) begin
          errors++;
          $display("FAIL busy_start_ignored cfg_err=%b expected 0", bus.cfg_err);
        end
      end
    end
    checks++;
    if (bus.sweep_count !== 16'd5) begin
      errors++;
      $display("FAIL carry_sweeps got %0d expected 5", bus.sweep_count);
    end
    pulse_abort();
    checks++;
    if (bus.busy !== 1'b0 || bus.frequency !== 32'd0 || bus.sweep_count !== 16'd5) begin
      errors++;
      $display("FAIL carry_abort busy=%b freq=%0h cnt=%0d expected 0 0 5",
               bus.busy, bus.frequency, bus.sweep_count);
    end
  endtask

  task automatic test_dwell_gating;
    logic pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    set_cfg(32'd100, 32'd200, 32'd10, 32'd3, 1'b0, 16'd0);
    bus.beat = 1'b0;
    pulse_start();
    bus.beat = 1'b1;  // lands in LOAD and must not count
    tick();
    checks++;
    if (bus.frequency !== 32'd100) begin
      errors++;
      $display("FAIL dwell_first got %0d expected 100", bus.frequency);
    end
    for (int i = 0; i < 6; i++) begin
      bus.beat = pat[i];
      tick();
      checks++;
      if (bus.frequency !== 32'd100) begin
        errors++;
        $display("FAIL dwell_hold%0d got %0d expected 100", i, bus.frequency);
      end
    end
    bus.beat = 1'b0;
    tick();
    checks++;
    if (bus.frequency !== 32'd110) begin
      errors++;
      $display("FAIL dwell_step got %0d expected 110", bus.frequency);
    end
    pulse_abort();
    bus.cfg_dwell = 32'd0;
    bus.beat = 1'b1;
    pulse_start();
    tick();
    tick();
    checks++;
    if (bus.frequency !== 32'd100) begin
      errors++;
      $display("FAIL dwell0_hold got %0d expected 100", bus.frequency);
    end
    tick();
    checks++;
    if (bus.frequency !== 32'd110) begin
      errors++;
      $display("FAIL dwell0_step got %0d expected 110", bus.frequency);
    end
    pulse_abort();
  endtask

  task automatic test_cfg_errors;
    set_cfg(32'd100, 32'd200, 32'd0, 32'd1, 1'b0, 16'd1);
    pulse_start();
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL err_step0 err=%b busy=%b done=%b expected 1 0 0",
               bus.cfg_err, bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got %b expected 0", bus.cfg_err);
    end
    set_cfg(32'd200, 32'd100, 32'd10, 32'd1, 1'b0, 16'd1);
    pulse_start();
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL err_order err=%b busy=%b expected 1 0", bus.cfg_err, bus.busy);
    end
    set_cfg(32'd100, 32'd100, 32'd10, 32'd1, 1'b0, 16'd0);
    pulse_start();
    checks++;
    if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL err_valid err=%b busy=%b expected 0 1", bus.cfg_err, bus.busy);
    end
    pulse_abort();
  endtask

  task automatic test_abort;
    set_cfg(32'd100, 32'd200, 32'd10, 32'd2, 1'b0, 16'd0);
    bus.beat = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (bus.frequency == 32'd110) break;
      tick();
    end
    checks++;
    if (bus.frequency !== 32'd110) begin
      errors++;
      $display("FAIL abort_reach got %0d expected 110", bus.frequency);
    end
    pulse_abort();
    checks++;
    if (bus.busy !== 1'b0 || bus.frequency !== 32'd0 || bus.amplitude !== 32'd0 ||
        bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy=%b freq=%0d amp=%0h done=%b expected 0 0 0 0",
               bus.busy, bus.frequency, bus.amplitude, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL start_abort busy=%b err=%b expected 0 0", bus.busy, bus.cfg_err);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.frequency !== 32'd0) begin
      errors++;
      $display("FAIL start_abort_hold busy=%b freq=%0d expected 0 0", bus.busy, bus.frequency);
    end
  endtask

  task automatic test_reset_mid;
    set_cfg(32'd100, 32'd100, 32'd10, 32'd1, 1'b0, 16'd0);
    bus.beat = 1'b1;
    pulse_start();
    tick();
    tick();
    tick();
    checks++;
    if (bus.frequency !== 32'd100 || bus.sweep_count !== 16'd1) begin
      errors++;
      $display("FAIL equal_bounds freq=%0d cnt=%0d expected 100 1",
               bus.frequency, bus.sweep_count);
    end
    tick();  // now in ADVANCE
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    checks++;
    if (bus.frequency !== 32'd0 || bus.amplitude !== 32'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.sweep_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid freq=%0d amp=%0h busy=%b done=%b cnt=%0d expected 0 0 0 0 0",
               bus.frequency, bus.amplitude, bus.busy, bus.done, bus.sweep_count);
    end
  endtask

  initial begin
    ARESET = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.beat  = 1'b0;
    bus.cfg_amplitude = 32'h0000_5A5A;
    set_cfg(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 16'd0);
    test_reset();
    test_sawtooth();
    test_triangle();
    test_carry_wrap();
    test_dwell_gating();
    test_cfg_errors();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramp_sweep_ctrl.md
Name: ramp_sweep_ctrl

Overview:
- Sequences the frequency/amplitude control words of the ramp generator to produce stepped frequency sweeps.
- Sits between the PS-side configuration registers and the generator's frequency/amplitude inputs.
- Counts consumed stream beats to hold each frequency for a programmed dwell, then steps in sawtooth or triangle fashion for N sweeps or indefinitely.
- Supports start/abort control, config validation, and done/error reporting.

Parameters:
FREQ_W, 32, width of frequency words (start/stop/step/output)
DWELL_W, 32, width of dwell counter
SWEEP_W, 16, width of sweep count and sweep counter

Ports:
ACLK  input  1  clock
ARESET  input  1  reset; synchronous, active-high
start  input  1  pulse; begin sweep using current cfg_* values
abort  input  1  pulse; stop immediately
cfg_start_freq  input  FREQ_W  first frequency word
cfg_stop_freq  input  FREQ_W  upper bound (inclusive)
cfg_step  input  FREQ_W  frequency increment per step
cfg_dwell  input  DWELL_W  beats per step; 0 treated as 1
cfg_amplitude  input  32  amplitude word driven while running
cfg_mode  input  1  0 = sawtooth, 1 = triangle
cfg_num_sweeps  input  SWEEP_W  0 = infinite, N = stop after N sweeps
beat  input  1  one generator output beat accepted downstream (TVALID & TREADY)
frequency  output  FREQ_W  to generator frequency input, registered
amplitude  output  32  to generator amplitude input, registered
busy  output  1  high in any state but IDLE
done  output  1  one-cycle pulse on normal completion
cfg_err  output  1  one-cycle pulse on rejected start
sweep_count  output  SWEEP_W  completed sweeps in the current run

Behaviour:
- Reset (ARESET=1 at a clock edge): state IDLE; frequency=0, amplitude=0, busy=0, done=0, cfg_err=0, sweep_count=0, direction=up, dwell counter=0. Reset mid-sweep has the same effect.
- States: IDLE, LOAD, DWELL, ADVANCE.
- IDLE:
  - start=1 with valid config: latch all cfg_* into shadow registers; go to LOAD; busy=1 from the next cycle; sweep_count<=0.
  - Invalid config is cfg_step==0 or cfg_start_freq>cfg_stop_freq: cfg_err pulses for 1 cycle; stay in IDLE.
  - cfg_* changes after the latch are ignored until the next start.
- LOAD (1 cycle): frequency<=start; amplitude<=cfg_amplitude; dwell counter<=max(cfg_dwell,1); direction<=up; go to DWELL.
  - Latency: start at cycle 0 gives new outputs visible at cycle 2.
- DWELL: each beat=1 decrements the dwell counter. A beat arriving while the counter is 1 moves the state to ADVANCE. Beats in LOAD or ADVANCE are not counted.
- ADVANCE (1 cycle): compute the next frequency with (FREQ_W+1)-bit arithmetic, reload the dwell counter, return to DWELL (or IDLE on completion).
  - Up: nxt = freq + step. If no carry and nxt <= stop, freq <= nxt. Otherwise boundary:
    - Sawtooth: one sweep is complete; freq <= start.
    - Triangle: direction <= down; freq <= max(freq - step, start), with borrow treated as below start.
  - Down (triangle only): nxt = freq - step. If no borrow and nxt >= start, freq <= nxt. Otherwise one sweep is complete; direction <= up; freq <= min(freq + step, stop).
  - On sweep completion, sweep_count increments. If cfg_num_sweeps != 0 and the new count equals it: go to IDLE, done pulses, frequency<=0, amplitude<=0, busy<=0. The frequency update for that cycle is discarded.
  - sweep_count saturates at all-ones when cfg_num_sweeps == 0.
- abort=1: from any state, go to IDLE next cycle; frequency<=0; amplitude<=0; busy<=0. No done pulse. sweep_count is held.
- Priorities: ARESET > abort > start. start while busy is ignored (no cfg_err).
- start==stop: frequency stays constant; each ADVANCE completes a sweep.
- done and cfg_err are never asserted in the same cycle.

Test Plan:
- Sawtooth, start=100, stop=130, step=10, dwell=2, sweeps=1, beat held high -> frequency 100,110,120,130, each for 2 DWELL beats plus ADVANCE/LOAD cycles; then done pulses once; frequency=0, amplitude=0, busy=0.
- Triangle, start=100, stop=125, step=10, dwell=1, sweeps=2 -> 100,110,120,110,100, then 110,120,110,100; sweep_count=1 then 2; done after the second return.
- Carry wrap, start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x10, sawtooth, sweeps=0 -> frequency alternates 0xFFFFFFF0 each step (carry means boundary); sweep_count increments per step; busy stays 1; no done.
- Dwell gating, dwell=3, beat toggled 1-0-0-1-0-1 -> frequency changes only after the third beat; dwell=0 behaves as dwell=1.
- Config errors: step=0 start -> cfg_err pulse, busy=0. Then start=200, stop=100 -> cfg_err pulse. Then a valid start -> busy=1 after 1 cycle.
- Abort/reset mid-sweep: abort during DWELL at frequency 110 -> next cycle IDLE, frequency=0, no done. start and abort in the same cycle from IDLE -> stays IDLE. ARESET during ADVANCE -> all outputs 0, sweep_count=0.
